// File: rtl/helen_nios_2_cpu_debug_mem_access_pkg.sv
// Shared types and constants for the JTAG debug memory-access engine.
package helen_nios_2_cpu_debug_mem_access_pkg;

  // Engine state: idle, or one Avalon-MM transfer in flight.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Bit positions inside the 38-bit jdo word captured by the sysclk stage.
  localparam int ADDR_LSB      = 17;
  localparam int RD_AFTER_LOAD = 35;
  localparam int CLR_ERR       = 36;
  localparam int WDATA_LSB     = 3;

  // Value left in MonDReg when a read is abandoned by the wait timeout.
  localparam logic [31:0] ERR_PATTERN_DEF = 32'hDEAD_DEAD;

endpackage

// File: rtl/helen_nios_2_cpu_debug_mem_timeout.sv
// Wait-state counter: cleared when a transfer starts, counts stalled cycles,
// and flags the stalled cycle on which the count would reach TIMEOUT.
module helen_nios_2_cpu_debug_mem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear has priority over counting a stalled cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This stalled cycle is the TIMEOUT-th one, so the transfer must end now.
  assign expired = en && !clr && (cnt_q == LIMIT);

endmodule

// File: rtl/helen_nios_2_cpu_debug_mem_access.sv
// JTAG debug memory-access engine: turns ocimem strobes plus jdo into single
// Avalon-MM reads/writes with auto-incrementing word address, returning read
// data on MonDReg and idle/error status to the TCK side.
module helen_nios_2_cpu_debug_mem_access
  import helen_nios_2_cpu_debug_mem_access_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_PATTERN = ERR_PATTERN_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         mon_q, mon_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                tmo_clr;
  logic                tmo_en;
  logic                tmo_expired;
  logic                any_strobe;
  logic                busy;

  // jdo bits outside every field are intentionally ignored.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign busy       = (state_q != ST_IDLE);
  assign tmo_en     = busy && avm_waitrequest;

  helen_nios_2_cpu_debug_mem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    err_d   = err_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    tmo_clr = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Priority ocimem_a > ocimem_b > no_action_a; losers are dropped.
        if (take_action_ocimem_a) begin
          addr_d = jdo[ADDR_LSB +: ADDR_W];
          if (jdo[CLR_ERR]) begin
            err_d = 1'b0;
          end
          if (jdo[RD_AFTER_LOAD]) begin
            state_d = ST_READ;
            rd_d    = 1'b1;
            ready_d = 1'b0;
            tmo_clr = 1'b1;
          end
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[WDATA_LSB +: 32];
          state_d = ST_WRITE;
          wr_d    = 1'b1;
          ready_d = 1'b0;
          tmo_clr = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_READ;
          rd_d    = 1'b1;
          ready_d = 1'b0;
          tmo_clr = 1'b1;
        end
      end

      ST_READ, ST_WRITE: begin
        // A strobe while busy is an overrun; the transfer itself carries on.
        if (any_strobe) begin
          err_d = 1'b1;
        end
        if (!avm_waitrequest) begin
          if (state_q == ST_READ) begin
            mon_d = avm_readdata;
          end
          addr_d  = addr_q + ADDR_W'(1);
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_expired) begin
          if (state_q == ST_READ) begin
            mon_d = ERR_PATTERN;
          end
          err_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;
  assign avm_address   = {addr_q, 2'b00};
  assign avm_read      = rd_q;
  assign avm_write     = wr_q;
  assign avm_writedata = wdata_q;

endmodule

// File: tb/tb_helen_nios_2_cpu_debug_mem_access.sv
// Directed bench for the JTAG debug memory-access engine (TIMEOUT = 8).
module tb_helen_nios_2_cpu_debug_mem_access;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [17:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int pass_cnt = 0;
  int total_cnt = 0;

  helen_nios_2_cpu_debug_mem_access #(
    .ADDR_W  (16),
    .TIMEOUT (8)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avm_address             (avm_address),
    .avm_read                (avm_read),
    .avm_write               (avm_write),
    .avm_writedata           (avm_writedata),
    .avm_readdata            (avm_readdata),
    .avm_waitrequest         (avm_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] jdo_a(input logic [15:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[32:17] = a;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // One-cycle strobe; returns 1 ns after the edge that sampled it.
  task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
    @(posedge clk); #1;
    jdo = j;
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avm_readdata = '0;
    avm_waitrequest = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total_cnt++;
    if ({monitor_ready, monitor_error, avm_read, avm_write} !== 4'b1000)
      $display("FAIL reset_status: got %b expected 1000", {monitor_ready, monitor_error, avm_read, avm_write});
    else pass_cnt++;
    total_cnt++;
    if (MonDReg !== 32'h0) $display("FAIL reset_mondreg: got 0x%0h expected 0x0", MonDReg);
    else pass_cnt++;
    total_cnt++;
    if (avm_writedata !== 32'h0) $display("FAIL reset_wdata: got 0x%0h expected 0x0", avm_writedata);
    else pass_cnt++;
  endtask

  task automatic test_load_and_read();
    avm_waitrequest = 1'b1;
    avm_readdata = 32'h1234_5678;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'h0010, 1'b1, 1'b0));
    // Edge 1 after strobe: request out, address 0x40.
    cmp("rd_req", {31'd0, avm_read}, 32'd1);
    cmp("rd_addr", {14'd0, avm_address}, 32'h40);
    step();
    step();
    cmp("rd_ready_low_cycle3", {31'd0, monitor_ready}, 32'd0);
    avm_waitrequest = 1'b0;
    step();
    cmp("rd_ready_cycle4", {31'd0, monitor_ready}, 32'd1);
    cmp("rd_req_drop", {31'd0, avm_read}, 32'd0);
    cmp("rd_data", MonDReg, 32'h1234_5678);
    // Address auto-incremented to 0x11 -> byte 0x44.
    avm_readdata = 32'h0BAD_F00D;
    pulse(1'b0, 1'b1, 1'b0, '0);
    cmp("rd_incr_addr", {14'd0, avm_address}, 32'h44);
    step();
    cmp("rd_min_latency_ready", {31'd0, monitor_ready}, 32'd1);
    cmp("rd2_data", MonDReg, 32'h0BAD_F00D);
  endtask

  task automatic test_streamed_writes();
    logic [31:0] wd [3];
    logic [17:0] wa [3];
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
    wa[0] = 18'h3FFFC; wa[1] = 18'h0; wa[2] = 18'h4;
    avm_waitrequest = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'hFFFF, 1'b0, 1'b0));
    cmp("load_no_read", {31'd0, avm_read}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b1, jdo_b(wd[i]));
      total_cnt++;
      if ({avm_write, avm_read, avm_address, avm_writedata} !== {1'b1, 1'b0, wa[i], wd[i]})
        $display("FAIL wr%0d: got w=%b r=%b a=0x%0h d=0x%0h expected w=1 r=0 a=0x%0h d=0x%0h",
                 i, avm_write, avm_read, avm_address, avm_writedata, wa[i], wd[i]);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({avm_write, monitor_ready} !== 2'b01)
        $display("FAIL wr%0d_done: got w=%b rdy=%b expected w=0 rdy=1", i, avm_write, monitor_ready);
      else pass_cnt++;
    end
    cmp("wr_mondreg_kept", MonDReg, 32'h0BAD_F00D);
  endtask

  task automatic test_timeout();
    int n;
    avm_waitrequest = 1'b1;
    pulse(1'b0, 1'b1, 1'b0, '0);
    cmp("tmo_addr", {14'd0, avm_address}, 32'h8);
    n = 0;
    while (avm_read && n < 50) begin
      step();
      n++;
    end
    cmp("tmo_wait_cycles", n, 8);
    cmp("tmo_mondreg", MonDReg, 32'hDEAD_DEAD);
    cmp("tmo_error", {31'd0, monitor_error}, 32'd1);
    cmp("tmo_ready", {31'd0, monitor_ready}, 32'd1);
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h55AA_0001;
    pulse(1'b0, 1'b1, 1'b0, '0);
    cmp("tmo_addr_unchanged", {14'd0, avm_address}, 32'h8);
    step();
    cmp("tmo_next_read", MonDReg, 32'h55AA_0001);
    cmp("tmo_error_sticky", {31'd0, monitor_error}, 32'd1);
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'h0020, 1'b0, 1'b1));
    cmp("tmo_error_clear", {31'd0, monitor_error}, 32'd0);
  endtask

  task automatic test_overrun_and_priority();
    avm_waitrequest = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, jdo_a(16'h0030, 1'b1, 1'b0));
    cmp("ovr_read_busy", {31'd0, avm_read}, 32'd1);
    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'h77));
    total_cnt++;
    if ({avm_read, avm_write, monitor_error} !== 3'b101)
      $display("FAIL ovr_during: got r=%b w=%b err=%b expected r=1 w=0 err=1",
               avm_read, avm_write, monitor_error);
    else pass_cnt++;
    cmp("ovr_addr_stable", {14'd0, avm_address}, 32'hC0);
    avm_waitrequest = 1'b0;
    avm_readdata = 32'hCAFE_F00D;
    step();
    cmp("ovr_read_done", MonDReg, 32'hCAFE_F00D);
    step();
    total_cnt++;
    if ({avm_write, monitor_ready, monitor_error} !== 3'b011)
      $display("FAIL ovr_after: got w=%b rdy=%b err=%b expected w=0 rdy=1 err=1",
               avm_write, monitor_ready, monitor_error);
    else pass_cnt++;
    // Simultaneous a + b in IDLE: only the load (with error clear) happens.
    pulse(1'b1, 1'b0, 1'b1, jdo_a(16'h0040, 1'b0, 1'b1));
    total_cnt++;
    if ({avm_write, avm_read, monitor_ready, monitor_error} !== 4'b0010)
      $display("FAIL prio_ab: got w=%b r=%b rdy=%b err=%b expected w=0 r=0 rdy=1 err=0",
               avm_write, avm_read, monitor_ready, monitor_error);
    else pass_cnt++;
    pulse(1'b0, 1'b1, 1'b0, '0);
    cmp("prio_loaded_addr", {14'd0, avm_address}, 32'h100);
    step();
  endtask

  task automatic test_reset_mid_transfer();
    avm_waitrequest = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, jdo_b(32'h1234));
    cmp("rst_mid_write_on", {31'd0, avm_write}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    cmp("rst_mid_write_drop", {31'd0, avm_write}, 32'd0);
    cmp("rst_mid_ready", {31'd0, monitor_ready}, 32'd1);
    #3;
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0000_0042;
    pulse(1'b0, 1'b1, 1'b0, '0);
    cmp("rst_mid_addr0", {14'd0, avm_address}, 32'h0);
    step();
    cmp("rst_mid_read_after", MonDReg, 32'h0000_0042);
  endtask

  initial begin
    test_reset();
    test_load_and_read();
    test_streamed_writes();
    test_timeout();
    test_overrun_and_priority();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
